// File: rtl/reg_stack_pkg.sv
// rtl/reg_stack_pkg.sv - shared defaults and push/pop operation decode for reg_stack
package reg_stack_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b01,
    OP_POP     = 2'b10,
    OP_REPLACE = 2'b11
  } op_t;

  function automatic op_t decode_op(input logic push, input logic pop);
    return op_t'({pop, push});
  endfunction

endpackage

// File: rtl/register_n.sv
// rtl/register_n.sv - WIDTH-bit loadable register with asynchronous clear
module register_n
  import reg_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else if (load) begin
      out <= in;
    end
  end

endmodule

// File: rtl/reg_stack.sv
// rtl/reg_stack.sv - register-file LIFO stack; REG_STACK_ERR_EN enables sticky overflow/underflow flags
module reg_stack
  import reg_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           in,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  op_t              op;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    wr_ptr;
  logic             wr_en;
  logic [DEPTH-1:0] load;
  logic [AW-1:0]    top_idx;
  logic [WIDTH-1:0] ent [DEPTH];

  assign op    = decode_op(push, pop);
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Replace on an empty stack degenerates to a push into entry 0.
  always_comb begin
    count_nxt = count_q;
    wr_en     = 1'b0;
    wr_ptr    = count_q;
    if (clear) begin
      count_nxt = '0;
    end else begin
      case (op)
        OP_PUSH: begin
          if (!full) begin
            wr_en     = 1'b1;
            count_nxt = count_q + CW'(1);
          end
        end
        OP_POP: begin
          if (!empty) count_nxt = count_q - CW'(1);
        end
        OP_REPLACE: begin
          wr_en = 1'b1;
          if (empty) count_nxt = CW'(1);
          else       wr_ptr    = count_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_nxt;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign load[i] = wr_en && (wr_ptr == CW'(i));
    register_n #(.WIDTH(WIDTH)) u_reg (
      .clk   (clk),
      .reset (reset),
      .load  (load[i]),
      .in    (in),
      .out   (ent[i])
    );
  end

  assign top_idx = AW'(count_q - CW'(1));
  assign out     = empty ? '0 : ent[top_idx];

`ifdef REG_STACK_ERR_EN
  logic ovf_q;
  logic unf_q;
  logic set_ovf;
  logic set_unf;

  assign set_ovf = !clear && (op == OP_PUSH) && full;
  assign set_unf = !clear && (op == OP_POP) && empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clear) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (set_ovf) ovf_q <= 1'b1;
      if (set_unf) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/reg_stack.md
REG_STACK -- requirements
Module: reg_stack

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of entries; legal range 2..256.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 in  input  WIDTH  SHALL be the word to push.
REQ-006 push  input  1  SHALL request a push of `in` at the next rising edge.
REQ-007 pop  input  1  SHALL request removal of the top entry at the next rising edge.
REQ-008 clear  input  1  SHALL synchronously empty the stack.
REQ-009 out  output  WIDTH  SHALL present the top entry, driven combinationally from storage.
REQ-010 count  output  $clog2(DEPTH+1)  SHALL present the number of valid entries.
REQ-011 empty  output  1  SHALL be high iff count == 0.
REQ-012 full  output  1  SHALL be high iff count == DEPTH.
REQ-013 overflow  output  1  SHALL be a sticky push-when-full error flag.
REQ-014 underflow  output  1  SHALL be a sticky pop-when-empty error flag.

Function
REQ-015 Operation priority SHALL be: reset > clear > push/pop.
REQ-016 A push with no pop and !full SHALL write `in` to entry[count] and increment count; `out` SHALL show the new word after that edge, a one-edge latency.
REQ-017 A pop with no push and !empty SHALL decrement count; the vacated entry keeps its stale data but is not observable.
REQ-018 Push and pop together with !empty SHALL replace the top entry with `in` and leave count unchanged.
REQ-019 Push and pop together with empty SHALL act as a plain push; underflow SHALL NOT be set.
REQ-020 A push while full and without pop SHALL be ignored, with storage and count unchanged, and SHALL set overflow.
REQ-021 A pop while empty and without push SHALL be ignored and SHALL set underflow.
REQ-022 `out` SHALL be 0 while empty.
REQ-023 clear SHALL set count to 0 and clear overflow and underflow; storage contents are don't-care.
REQ-024 Count arithmetic SHALL never wrap: it is saturated at 0 and at DEPTH by REQ-020 and REQ-021.
REQ-025 The data path SHALL be signed-agnostic: words are stored bit-exact.

Reset
REQ-026 Assertion of reset SHALL immediately force count=0, all entries=0, overflow=0 and underflow=0, so that out=0, empty=1 and full=0, independent of clk.
REQ-027 While reset is high, push, pop and clear SHALL be ignored; on deassertion, the first effective edge is the next rising clk.
REQ-028 Reset asserted mid-operation, including in the same cycle as a push, SHALL discard that operation.

Configuration
REQ-029 Macro REG_STACK_ERR_EN SHALL control the error flags.
REQ-030 With REG_STACK_ERR_EN defined, overflow and underflow SHALL behave per REQ-013, REQ-014, REQ-020, REQ-021 and REQ-023.
REQ-031 Without REG_STACK_ERR_EN, the overflow and underflow ports SHALL remain present but be tied to 0, and no flag flip-flops SHALL be synthesised.
REQ-032 The ignore behaviour of REQ-020 and REQ-021 SHALL hold with or without the macro.

Structure
REQ-033 Package reg_stack_pkg SHALL hold the WIDTH and DEPTH default constants and an op enum {OP_NOP, OP_PUSH, OP_POP, OP_REPLACE} decoded from push and pop.
REQ-034 Each storage entry SHALL be one instance of sub-module register_n, a WIDTH-parametrised register with in, load, clk, reset and out, whose load comes from the write-pointer decode.
REQ-035 The top-of-stack read mux SHALL index entry[count-1].

Verification
REQ-036 Reset, then idle for 2 clocks -> out=0, count=0, empty=1, full=0, overflow=0, underflow=0.
REQ-037 Push -32123, then push 12345 -> after the 1st edge out=-32123 and count=1; after the 2nd edge out=12345 and count=2; pop -> out=-32123 and count=1.
REQ-038 DEPTH=8: push 1..8 -> full=1 and out=8; push 9 -> out=8, count=8, overflow=1; pop 8 times -> out 7,6,...,1, then 0 with empty=1.
REQ-039 Empty stack, pop -> underflow=1 and count=0; push and pop together with in=11111 -> out=11111 and count=1; push and pop together with in=1 -> out=1 and count=1.
REQ-040 With 3 entries and overflow set, raise clear -> count=0, out=0, overflow=0; assert reset asynchronously between clock edges after pushes -> out=0 immediately.
REQ-041 Rebuild the bench without REG_STACK_ERR_EN and repeat REQ-038 and REQ-039 -> same data and count behaviour, with overflow=0 and underflow=0 throughout.
